// File: rtl/sha256_mem_responder.sv
// ---------------------------------------------------------------------------
// sha256_mem_responder
//
// Memory-mapped companion for a SHA-256 core. A host streams NUM_OF_WORDS
// message words into an internal word memory, the block pulses core_start,
// serves the core's memory reads/writes while it runs, and then streams the
// 8-word digest (written by the core into the HASH_ADDR window) back out.
//
// Ports
//   clk, rst          : single clock (rising edge), asynchronous active-high reset
//   mem_addr/we/wdata : core memory access (writes honoured only while the core runs)
//   mem_rdata         : registered read data to the core, 1-cycle latency
//   core_start        : one-cycle job start pulse
//   core_done         : core idle/done level
//   core_input_addr   : constant INPUT_ADDR
//   core_hash_addr    : constant HASH_ADDR
//   in_valid/ready/data   : host message word stream (accepted in LOAD only)
//   out_valid/ready/data  : digest word stream (8 words, one per two cycles at best)
//   busy              : high whenever not in LOAD
//   err               : sticky flag, core wrote outside the digest window
// ---------------------------------------------------------------------------
module sha256_mem_responder #(
    parameter int          DEPTH        = 256,
    parameter int          NUM_OF_WORDS = 40,
    parameter logic [15:0] INPUT_ADDR   = 16'h0000,
    parameter logic [15:0] HASH_ADDR    = 16'h0080
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] mem_addr,
    input  logic        mem_we,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        core_start,
    input  logic        core_done,
    output logic [15:0] core_input_addr,
    output logic [15:0] core_hash_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        err
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [16:0] DEPTH_W  = 17'(DEPTH);
    localparam logic [6:0]  LAST_CNT = 7'(NUM_OF_WORDS - 1);

    typedef enum logic [2:0] {
        LOAD,
        START,
        WAIT_LOW,
        WAIT_DONE,
        UNLOAD_RD,
        UNLOAD_OUT
    } state_t;

    state_t      r_state;
    logic [6:0]  r_cnt;
    logic [2:0]  r_k;
    logic        r_core_start;
    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic        r_err;
    logic [31:0] r_mem_rdata;

    logic [31:0] r_mem [0:DEPTH-1];

    logic [15:0]   w_host_addr;
    logic [15:0]   w_hash_addr;
    logic [15:0]   w_core_off;
    logic          w_host_acc;
    logic          w_host_ok;
    logic          w_hash_ok;
    logic          w_core_ok;
    logic          w_core_state;
    logic          w_core_wr;
    logic          w_core_in_win;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [31:0]   w_wdata;

    // Address sums are 16-bit, so they wrap before being range checked.
    assign w_host_addr  = INPUT_ADDR + {9'd0, r_cnt};
    assign w_hash_addr  = HASH_ADDR + {13'd0, r_k};
    assign w_host_ok    = ({1'b0, w_host_addr} < DEPTH_W);
    assign w_hash_ok    = ({1'b0, w_hash_addr} < DEPTH_W);
    assign w_core_ok    = ({1'b0, mem_addr} < DEPTH_W);

    // Window test via wrapped offset so a window near 0xFFFF still works.
    assign w_core_off    = mem_addr - HASH_ADDR;
    assign w_core_in_win = (w_core_off < 16'd8);

    assign w_host_acc   = (r_state == LOAD) && in_valid;
    assign w_core_state = (r_state == WAIT_LOW) || (r_state == WAIT_DONE);
    assign w_core_wr    = w_core_state && mem_we;

    // Host and core writes are exclusive by state, so one write port suffices.
    assign w_we    = (w_host_acc && w_host_ok) || (w_core_wr && w_core_ok);
    assign w_waddr = w_host_acc ? w_host_addr[AW-1:0] : mem_addr[AW-1:0];
    assign w_wdata = w_host_acc ? in_data : mem_wdata;

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Core read port: runs every cycle regardless of state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_rdata <= 32'd0;
        end else if (w_core_ok) begin
            r_mem_rdata <= r_mem[mem_addr[AW-1:0]];
        end else begin
            r_mem_rdata <= 32'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= LOAD;
            r_cnt        <= 7'd0;
            r_k          <= 3'd0;
            r_core_start <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= 32'd0;
            r_err        <= 1'b0;
        end else begin
            r_core_start <= 1'b0;
            // Any honoured core write outside the digest window flags, even
            // when the address is beyond DEPTH and the write itself is dropped.
            if (w_core_wr && !w_core_in_win) begin
                r_err <= 1'b1;
            end
            case (r_state)
                LOAD: begin
                    if (in_valid) begin
                        if (r_cnt == LAST_CNT) begin
                            r_cnt        <= 7'd0;
                            r_state      <= START;
                            r_core_start <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 7'd1;
                        end
                    end
                end
                START: begin
                    r_state <= WAIT_LOW;
                end
                // core_done is high while idle; wait for it to drop first so
                // the idle level is not mistaken for completion.
                WAIT_LOW: begin
                    if (!core_done) begin
                        r_state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (core_done) begin
                        r_state <= UNLOAD_RD;
                        r_k     <= 3'd0;
                    end
                end
                // Second read port: digest word fetched straight into the
                // output register, giving the intended one-cycle bubble.
                UNLOAD_RD: begin
                    r_out_data  <= w_hash_ok ? r_mem[w_hash_addr[AW-1:0]] : 32'd0;
                    r_out_valid <= 1'b1;
                    r_state     <= UNLOAD_OUT;
                end
                UNLOAD_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_k != 3'd7) begin
                            r_k     <= r_k + 3'd1;
                            r_state <= UNLOAD_RD;
                        end else begin
                            r_k     <= 3'd0;
                            r_state <= LOAD;
                        end
                    end
                end
                default: begin
                    r_state <= LOAD;
                end
            endcase
        end
    end

    assign mem_rdata       = r_mem_rdata;
    assign core_start      = r_core_start;
    assign core_input_addr = INPUT_ADDR;
    assign core_hash_addr  = HASH_ADDR;
    assign in_ready        = (r_state == LOAD);
    assign busy            = (r_state != LOAD);
    assign out_valid       = r_out_valid;
    assign out_data        = r_out_data;
    assign err             = r_err;

endmodule

// File: tb/tb_sha256_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_sha256_mem_responder
//
// Drives a full job (load, start, core handshake, core digest writes, unload),
// plus read latency, error flag, back-to-back job and reset mid-job scenarios.
// Expected read data and digest words go into queues as stimulus is driven
// and are popped when the DUT presents them.
// ---------------------------------------------------------------------------
module tb_sha256_mem_responder;

    logic        clk;
    logic        rst;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        core_start;
    logic        core_done;
    logic [15:0] core_input_addr;
    logic [15:0] core_hash_addr;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int t_drop   = 0;

    logic [31:0] rd_q[$];
    logic [31:0] dg_q[$];

    sha256_mem_responder #(
        .DEPTH(256),
        .NUM_OF_WORDS(40),
        .INPUT_ADDR(16'h0000),
        .HASH_ADDR(16'h0080)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mem_addr(mem_addr),
        .mem_we(mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .core_start(core_start),
        .core_done(core_done),
        .core_input_addr(core_input_addr),
        .core_hash_addr(core_hash_addr),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .busy(busy),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reset held across two edges; outputs checked while rst is still high.
    task automatic test_reset();
        rst       = 1'b1;
        mem_addr  = 16'd5;
        mem_we    = 1'b0;
        mem_wdata = 32'd0;
        core_done = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({in_ready, busy, out_valid, core_start, err} !== 5'b10000)
            $display("FAIL reset_flags got %b need 10000", {in_ready, busy, out_valid, core_start, err});
        else n_pass++;
        n_checks++;
        if (mem_rdata !== 32'd0 || out_data !== 32'd0)
            $display("FAIL reset_data got rdata=%h out=%h need 0", mem_rdata, out_data);
        else n_pass++;
        n_checks++;
        if (core_input_addr !== 16'h0000 || core_hash_addr !== 16'h0080)
            $display("FAIL const_addr got %h/%h need 0000/0080", core_input_addr, core_hash_addr);
        else n_pass++;
        rst = 1'b0;
        $display("reset released at cycle %0d", cyc);
    endtask

    // Streams 40 words with in_valid held; checks start pulse timing, then
    // drops core_done two cycles after START.
    task automatic load_job(input logic [31:0] base, input string tag);
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_data = base + 32'(i);
            n_checks++;
            if (in_ready !== 1'b1)
                $display("FAIL %s_in_ready word %0d got %b need 1", tag, i, in_ready);
            else n_pass++;
            @(posedge clk);
            #1;
            $display("%s load word %0d data=%h", tag, i, base + 32'(i));
        end
        in_valid = 1'b0;
        n_checks++;
        if ({in_ready, core_start, busy} !== 3'b011)
            $display("FAIL %s_start got in_ready,core_start,busy=%b need 011", tag, {in_ready, core_start, busy});
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (core_start !== 1'b0)
            $display("FAIL %s_start_width got core_start=%b need 0", tag, core_start);
        else n_pass++;
        @(posedge clk);
        #1;
        core_done = 1'b0;
        t_drop    = cyc;
    endtask

    task automatic test_load();
        load_job(32'h0000_0000, "job1");
    endtask

    // Reads back the message and probes out-of-range reads.
    task automatic test_read_latency();
        logic [31:0] exp;
        for (int i = 0; i < 42; i++) begin
            if (i < 40) begin
                mem_addr = 16'(i);
                rd_q.push_back(32'(i));
            end else if (i == 40) begin
                mem_addr = 16'd5;
                rd_q.push_back(32'h0000_0005);
            end else begin
                mem_addr = 16'h0100;
                rd_q.push_back(32'h0000_0000);
            end
            @(posedge clk);
            #1;
            exp = rd_q.pop_front();
            n_checks++;
            if (mem_rdata !== exp)
                $display("FAIL rd_addr_%h got %h need %h", mem_addr, mem_rdata, exp);
            else n_pass++;
            $display("read addr=%h data=%h", mem_addr, mem_rdata);
        end
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL early_unload got out_valid=%b busy=%b need 0/1", out_valid, busy);
        else n_pass++;
    endtask

    // Core writes the digest while host spams in_valid (must be ignored).
    task automatic test_core_writes();
        in_valid = 1'b1;
        in_data  = 32'h0BAD_0BAD;
        for (int i = 0; i < 8; i++) begin
            mem_we    = 1'b1;
            mem_addr  = 16'h0080 + 16'(i);
            mem_wdata = 32'h0000_00A0 + 32'(i);
            dg_q.push_back(32'h0000_00A0 + 32'(i));
            @(posedge clk);
            #1;
            $display("core write addr=%h data=%h", mem_addr, mem_wdata);
        end
        mem_we   = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (err !== 1'b0)
            $display("FAIL err_in_window got %b need 0", err);
        else n_pass++;
    endtask

    task automatic test_error();
        logic [31:0] exp;
        mem_we    = 1'b1;
        mem_addr  = 16'h0010;
        mem_wdata = 32'hCAFE_0010;
        @(posedge clk);
        #1;
        mem_we = 1'b0;
        n_checks++;
        if (err !== 1'b1)
            $display("FAIL err_set got %b need 1", err);
        else n_pass++;
        mem_we    = 1'b1;
        mem_addr  = 16'h0100;
        mem_wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        mem_we = 1'b0;
        n_checks++;
        if (err !== 1'b1)
            $display("FAIL err_sticky got %b need 1", err);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            mem_addr = (i == 0) ? 16'h0010 : (i == 1) ? 16'h0000 : 16'h0100;
            rd_q.push_back((i == 0) ? 32'hCAFE_0010 : 32'h0000_0000);
            @(posedge clk);
            #1;
            exp = rd_q.pop_front();
            n_checks++;
            if (mem_rdata !== exp)
                $display("FAIL err_rd_%h got %h need %h", mem_addr, mem_rdata, exp);
            else n_pass++;
            $display("read addr=%h data=%h", mem_addr, mem_rdata);
        end
    endtask

    // Hold core_done low until 100 cycles after the drop, then raise it.
    task automatic test_done_handshake();
        logic early;
        early = 1'b0;
        while (cyc < t_drop + 100) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || busy !== 1'b1) early = 1'b1;
        end
        n_checks++;
        if (early !== 1'b0)
            $display("FAIL done_wait got early unload=%b need 0", early);
        else n_pass++;
        core_done = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL unload_rd got out_valid=%b busy=%b need 0/1", out_valid, busy);
        else n_pass++;
    endtask

    task automatic test_unload();
        logic [31:0] exp;
        int          waited;
        out_ready = 1'b0;
        for (int w = 0; w < 8; w++) begin
            waited = 0;
            while (out_valid !== 1'b1 && waited < 10) begin
                @(posedge clk);
                #1;
                waited++;
            end
            n_checks++;
            if (out_valid !== 1'b1) begin
                $display("FAIL unload_timeout word %0d got out_valid=%b need 1", w, out_valid);
                break;
            end else n_pass++;
            exp = (dg_q.size() > 0) ? dg_q.pop_front() : 32'hFFFF_FFFF;
            n_checks++;
            if (out_data !== exp)
                $display("FAIL digest_%0d got %h need %h", w, out_data, exp);
            else n_pass++;
            $display("digest word %0d data=%h", w, out_data);
            if (w == 2) begin
                for (int s = 0; s < 3; s++) begin
                    @(posedge clk);
                    #1;
                    n_checks++;
                    if (out_valid !== 1'b1 || out_data !== exp)
                        $display("FAIL stall_%0d got valid=%b data=%h need 1/%h", s, out_valid, out_data, exp);
                    else n_pass++;
                end
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            n_checks++;
            if (out_valid !== 1'b0)
                $display("FAIL bubble_%0d got out_valid=%b need 0", w, out_valid);
            else n_pass++;
        end
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL unload_end got busy=%b in_ready=%b need 0/1", busy, in_ready);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        load_job(32'h0000_0100, "job2");
        @(posedge clk);
        #1;
        mem_we    = 1'b1;
        mem_addr  = 16'h0011;
        mem_wdata = 32'h5555_0011;
        @(posedge clk);
        #1;
        mem_we = 1'b0;
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b1)
            $display("FAIL job2_err got err=%b busy=%b need 1/1", err, busy);
        else n_pass++;
    endtask

    // Asynchronous reset in WAIT_DONE, then a core write during LOAD.
    task automatic test_reset_mid_job();
        logic [31:0] exp;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, busy, out_valid, core_start, err} !== 5'b10000)
            $display("FAIL midrst_flags got %b need 10000", {in_ready, busy, out_valid, core_start, err});
        else n_pass++;
        n_checks++;
        if (mem_rdata !== 32'd0)
            $display("FAIL midrst_rdata got %h need 0", mem_rdata);
        else n_pass++;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        core_done = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 16'h0080;
        mem_wdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        mem_we = 1'b0;
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b0)
            $display("FAIL load_we_err got err=%b busy=%b need 0/0", err, busy);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            mem_addr = (i == 0) ? 16'h0080 : (i == 1) ? 16'h0000 : 16'h0011;
            rd_q.push_back((i == 0) ? 32'h0000_00A0 : (i == 1) ? 32'h0000_0100 : 32'h5555_0011);
            @(posedge clk);
            #1;
            exp = rd_q.pop_front();
            n_checks++;
            if (mem_rdata !== exp)
                $display("FAIL midrst_rd_%h got %h need %h", mem_addr, mem_rdata, exp);
            else n_pass++;
            $display("read addr=%h data=%h", mem_addr, mem_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_read_latency();
        test_core_writes();
        test_error();
        test_done_handshake();
        test_unload();
        test_back_to_back();
        test_reset_mid_job();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
